// File: rtl/func_gen_pkg.sv
// Shared types and reset constants for the func_gen_dds phase-accumulator generator.
package func_gen_pkg;

    typedef enum logic [2:0] {
        SINE     = 3'd0,
        TRIANGLE = 3'd1,
        SQUARE   = 3'd2,
        PWM      = 3'd3,
        SAWTOOTH = 3'd4
    } signal_t;

    // Active configuration after reset: zero increment, sine, duty 0, full amplitude.
    localparam signal_t RST_SIG_TYPE = SINE;
    localparam logic    RST_INC_BIT  = 1'b0;
    localparam logic    RST_DUTY_BIT = 1'b0;
    localparam logic    RST_AMP_BIT  = 1'b1;

endpackage

// File: rtl/func_gen_dds_phase_acc.sv
// Phase register plus shadow configuration that is applied at a wrap, or at once while idle.
// Carries the amplitude field only when FUNC_GEN_AMP_SCALE_EN is defined.
module func_gen_dds_phase_acc
    import func_gen_pkg::*;
#(
    parameter int unsigned DATA_W  = 8,
    parameter int unsigned PHASE_W = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic               cfg_valid,
    output logic               cfg_ready,
    input  logic [PHASE_W-1:0] cfg_phase_inc,
    input  logic [2:0]         cfg_sig_type,
    input  logic [DATA_W-1:0]  cfg_duty,
`ifdef FUNC_GEN_AMP_SCALE_EN
    input  logic [DATA_W-1:0]  cfg_amp,
    output logic [DATA_W-1:0]  amp,
`endif
    output logic [PHASE_W-1:0] phase,
    output logic               phase_zero,
    output signal_t            sig_type,
    output logic [DATA_W-1:0]  duty
);

    logic [PHASE_W-1:0] phase_q, phase_d, inc_q, shd_inc_q;
    logic [DATA_W-1:0]  duty_q, shd_duty_q;
    signal_t            type_q, shd_type_q;
    logic               shd_full_q, ready_q;
    logic [PHASE_W:0]   sum;
    logic               wrap, transfer, apply;
`ifdef FUNC_GEN_AMP_SCALE_EN
    logic [DATA_W-1:0]  amp_q, shd_amp_q;
`endif

    assign sum      = {1'b0, phase_q} + {1'b0, inc_q};
    assign wrap     = en && sum[PHASE_W];
    assign transfer = cfg_valid && ready_q;
    // Idle cycles have no period in flight, so a pending config may land immediately.
    assign apply    = shd_full_q && (wrap || !en);

    always_comb begin
        phase_d = phase_q;
        if (apply) begin
            phase_d = '0;
        end else if (en) begin
            phase_d = sum[PHASE_W-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            phase_q    <= '0;
            inc_q      <= {PHASE_W{RST_INC_BIT}};
            type_q     <= RST_SIG_TYPE;
            duty_q     <= {DATA_W{RST_DUTY_BIT}};
            shd_inc_q  <= '0;
            shd_type_q <= RST_SIG_TYPE;
            shd_duty_q <= '0;
            shd_full_q <= 1'b0;
            ready_q    <= 1'b0;
        end else begin
            phase_q <= phase_d;
            ready_q <= !(transfer || (shd_full_q && !apply));
            if (transfer) begin
                shd_full_q <= 1'b1;
                shd_inc_q  <= cfg_phase_inc;
                shd_type_q <= signal_t'(cfg_sig_type);
                shd_duty_q <= cfg_duty;
            end else if (apply) begin
                shd_full_q <= 1'b0;
            end
            if (apply) begin
                inc_q  <= shd_inc_q;
                type_q <= shd_type_q;
                duty_q <= shd_duty_q;
            end
        end
    end

`ifdef FUNC_GEN_AMP_SCALE_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            amp_q     <= {DATA_W{RST_AMP_BIT}};
            shd_amp_q <= '0;
        end else begin
            if (transfer) shd_amp_q <= cfg_amp;
            if (apply) amp_q <= shd_amp_q;
        end
    end

    assign amp = amp_q;
`endif

    assign cfg_ready  = ready_q;
    assign phase      = phase_q;
    assign phase_zero = (phase_q == '0);
    assign sig_type   = type_q;
    assign duty       = duty_q;

endmodule

// File: rtl/func_gen_dds.sv
// DDS function generator: computed waveforms are delayed to line up with the sine BRAM read.
// Optional amplitude scaling is enabled by defining FUNC_GEN_AMP_SCALE_EN.
module func_gen_dds
    import func_gen_pkg::*;
#(
    parameter int unsigned DATA_W  = 8,
    parameter int unsigned PHASE_W = 32,
    parameter int unsigned LUT_AW  = 10,
    parameter int unsigned LUT_LAT = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic               cfg_valid,
    output logic               cfg_ready,
    input  logic [PHASE_W-1:0] cfg_phase_inc,
    input  logic [2:0]         cfg_sig_type,
    input  logic [DATA_W-1:0]  cfg_duty,
    input  logic [DATA_W-1:0]  cfg_amp,
    output logic [LUT_AW-1:0]  lut_addr,
    input  logic [DATA_W-1:0]  lut_data,
    output logic [DATA_W-1:0]  sample,
    output logic               sample_valid,
    output logic               cycle_start
);

    localparam int unsigned LAST = LUT_LAT - 1;

    logic [PHASE_W-1:0] phase;
    logic               phase_zero;
    signal_t            sig_type;
    logic [DATA_W-1:0]  duty, t_val, u_val, comp, raw, scaled;
    logic [DATA_W-1:0]  sample_q;
    logic               valid_q, start_q, unused_phase;

`ifdef FUNC_GEN_AMP_SCALE_EN
    logic [DATA_W-1:0]   amp;
    logic [2*DATA_W-1:0] prod;
`else
    logic unused_amp;
    assign unused_amp = ^cfg_amp;
`endif

    func_gen_dds_phase_acc #(
        .DATA_W (DATA_W),
        .PHASE_W(PHASE_W)
    ) u_phase_acc (
        .clk          (clk),
        .rst          (rst),
        .en           (en),
        .cfg_valid    (cfg_valid),
        .cfg_ready    (cfg_ready),
        .cfg_phase_inc(cfg_phase_inc),
        .cfg_sig_type (cfg_sig_type),
        .cfg_duty     (cfg_duty),
`ifdef FUNC_GEN_AMP_SCALE_EN
        .cfg_amp      (cfg_amp),
        .amp          (amp),
`endif
        .phase        (phase),
        .phase_zero   (phase_zero),
        .sig_type     (sig_type),
        .duty         (duty)
    );

    assign lut_addr     = phase[PHASE_W-1 -: LUT_AW];
    assign t_val        = phase[PHASE_W-1 -: DATA_W];
    assign u_val        = phase[PHASE_W-2 -: DATA_W];
    assign unused_phase = ^phase;

    always_comb begin
        comp = '0;
        case (sig_type)
            TRIANGLE: comp = phase[PHASE_W-1] ? ~u_val : u_val;
            SQUARE:   comp = phase[PHASE_W-1] ? '0 : '1;
            PWM:      comp = (t_val < duty) ? '1 : '0;
            SAWTOOTH: comp = t_val;
            default:  comp = '0;
        endcase
    end

    // Each stage carries one phase's computed value and tags alongside the BRAM read.
    for (genvar g = 0; g < LUT_LAT; g++) begin : g_dly
        logic [DATA_W-1:0] comp_q, comp_in;
        signal_t           type_q, type_in;
        logic              en_q, en_in, zero_q, zero_in;
`ifdef FUNC_GEN_AMP_SCALE_EN
        logic [DATA_W-1:0] amp_q, amp_in;
`endif
        if (g == 0) begin : g_src
            assign comp_in = comp;
            assign type_in = sig_type;
            assign en_in   = en;
            assign zero_in = phase_zero;
`ifdef FUNC_GEN_AMP_SCALE_EN
            assign amp_in  = amp;
`endif
        end else begin : g_src
            assign comp_in = g_dly[g-1].comp_q;
            assign type_in = g_dly[g-1].type_q;
            assign en_in   = g_dly[g-1].en_q;
            assign zero_in = g_dly[g-1].zero_q;
`ifdef FUNC_GEN_AMP_SCALE_EN
            assign amp_in  = g_dly[g-1].amp_q;
`endif
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                comp_q <= '0;
                type_q <= RST_SIG_TYPE;
                en_q   <= 1'b0;
                zero_q <= 1'b0;
`ifdef FUNC_GEN_AMP_SCALE_EN
                amp_q  <= '0;
`endif
            end else begin
                comp_q <= comp_in;
                type_q <= type_in;
                en_q   <= en_in;
                zero_q <= zero_in;
`ifdef FUNC_GEN_AMP_SCALE_EN
                amp_q  <= amp_in;
`endif
            end
        end
    end

    assign raw = (g_dly[LAST].type_q == SINE) ? lut_data : g_dly[LAST].comp_q;

`ifdef FUNC_GEN_AMP_SCALE_EN
    assign prod   = {{DATA_W{1'b0}}, raw} * {{DATA_W{1'b0}}, g_dly[LAST].amp_q};
    assign scaled = prod[2*DATA_W-1:DATA_W];
`else
    assign scaled = raw;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            sample_q <= '0;
            valid_q  <= 1'b0;
            start_q  <= 1'b0;
        end else begin
            valid_q <= g_dly[LAST].en_q;
            start_q <= g_dly[LAST].en_q && g_dly[LAST].zero_q;
            if (g_dly[LAST].en_q) sample_q <= scaled;
        end
    end

    assign sample       = sample_q;
    assign sample_valid = valid_q;
    assign cycle_start  = start_q;

endmodule

// File: tb/tb_func_gen_dds.sv
// Bench for func_gen_dds: two instances (BRAM latency 1 and 2) against a behavioural model.
module tb_func_gen_dds;
    import func_gen_pkg::*;

`ifdef FUNC_GEN_AMP_SCALE_EN
    localparam bit AMP_EN = 1'b1;
`else
    localparam bit AMP_EN = 1'b0;
`endif
    localparam longint unsigned FULL = 64'h1_0000_0000;
    localparam longint unsigned HALF = 64'h8000_0000;

    typedef struct {
        bit          en;
        int unsigned val;
        bit          zero;
    } ent_t;

    logic        clk = 1'b0, rst = 1'b1, en = 1'b0, cfg_valid = 1'b0;
    logic [31:0] cfg_phase_inc = '0;
    logic [2:0]  cfg_sig_type = '0;
    logic [7:0]  cfg_duty = '0, cfg_amp = 8'hff;
    logic        ready1, ready2, v1, v2, cs1, cs2;
    logic [9:0]  addr1, addr2;
    logic [7:0]  data1 = '0, data2 = '0, data2a = '0, smp1, smp2;
    logic [7:0]  lut [1024];

    int total = 0, bad = 0;

    longint unsigned m_phase, m_inc, s_inc;
    int unsigned     m_type, m_duty, m_amp, s_type, s_duty, s_amp;
    bit              m_shd, m_ready, accepted;
    ent_t            q1[$], q2[$];
    int unsigned     e_s1, e_s2;
    bit              e_v1, e_v2, e_cs1, e_cs2;

    always #5 clk = ~clk;

    // External BRAM models with read latency 1 and 2.
    always @(posedge clk) begin
        data1  <= lut[addr1];
        data2a <= lut[addr2];
        data2  <= data2a;
    end

    func_gen_dds #(.DATA_W(8), .PHASE_W(32), .LUT_AW(10), .LUT_LAT(1)) dut1 (
        .clk(clk), .rst(rst), .en(en), .cfg_valid(cfg_valid), .cfg_ready(ready1),
        .cfg_phase_inc(cfg_phase_inc), .cfg_sig_type(cfg_sig_type), .cfg_duty(cfg_duty),
        .cfg_amp(cfg_amp), .lut_addr(addr1), .lut_data(data1), .sample(smp1),
        .sample_valid(v1), .cycle_start(cs1)
    );

    func_gen_dds #(.DATA_W(8), .PHASE_W(32), .LUT_AW(10), .LUT_LAT(2)) dut2 (
        .clk(clk), .rst(rst), .en(en), .cfg_valid(cfg_valid), .cfg_ready(ready2),
        .cfg_phase_inc(cfg_phase_inc), .cfg_sig_type(cfg_sig_type), .cfg_duty(cfg_duty),
        .cfg_amp(cfg_amp), .lut_addr(addr2), .lut_data(data2), .sample(smp2),
        .sample_valid(v2), .cycle_start(cs2)
    );

    function automatic int unsigned model_val(longint unsigned ph, int unsigned ty,
                                              int unsigned duty, int unsigned amp);
        int unsigned t, u, raw;
        t = int'(ph >> 24);
        u = int'((ph >> 23) % 256);
        case (ty)
            0:       raw = lut[int'(ph >> 22)];
            1:       raw = (ph < HALF) ? u : 255 - u;
            2:       raw = (ph < HALF) ? 255 : 0;
            3:       raw = (t < duty) ? 255 : 0;
            4:       raw = t;
            default: raw = 0;
        endcase
        return AMP_EN ? (raw * amp) / 256 : raw;
    endfunction

    task automatic check(string tag, int unsigned obs, int unsigned exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_phase = 0; m_inc = 0; m_type = 0; m_duty = 0; m_amp = 255;
        m_shd = 0; m_ready = 0;
        s_inc = 0; s_type = 0; s_duty = 0; s_amp = 0;
        q1 = {}; q2 = {};
        q1.push_back('{0, 0, 0});
        q2.push_back('{0, 0, 0}); q2.push_back('{0, 0, 0});
        e_s1 = 0; e_s2 = 0; e_v1 = 0; e_v2 = 0; e_cs1 = 0; e_cs2 = 0;
    endtask

    task automatic tick();
        ent_t e, o;
        bit tr, ap, wr;
        longint unsigned sum;
        e.en   = en;
        e.val  = model_val(m_phase, m_type, m_duty, m_amp);
        e.zero = (m_phase == 0);
        sum = m_phase + m_inc;
        wr  = en && (sum >= FULL);
        tr  = cfg_valid && m_ready;
        ap  = m_shd && (wr || !en);
        @(posedge clk);
        accepted = 0;
        if (rst) begin
            model_reset();
        end else begin
            q1.push_back(e); o = q1.pop_front();
            e_v1 = o.en; e_cs1 = o.en && o.zero; if (o.en) e_s1 = o.val;
            q2.push_back(e); o = q2.pop_front();
            e_v2 = o.en; e_cs2 = o.en && o.zero; if (o.en) e_s2 = o.val;
            if (ap) begin
                m_phase = 0; m_inc = s_inc; m_type = s_type; m_duty = s_duty; m_amp = s_amp;
                m_shd = 0;
            end else if (en) begin
                m_phase = sum % FULL;
            end
            if (tr) begin
                m_shd = 1; s_inc = cfg_phase_inc; s_type = cfg_sig_type;
                s_duty = cfg_duty; s_amp = cfg_amp;
            end
            m_ready  = !m_shd;
            accepted = tr;
        end
        #1;
        check("addr1", addr1, int'(m_phase >> 22));
        check("addr2", addr2, int'(m_phase >> 22));
        check("ready1", ready1, m_ready);
        check("ready2", ready2, m_ready);
        check("sample1", smp1, e_s1);
        check("valid1", v1, e_v1);
        check("start1", cs1, e_cs1);
        check("sample2", smp2, e_s2);
        check("valid2", v2, e_v2);
        check("start2", cs2, e_cs2);
    endtask

    task automatic run(int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic offer(logic [31:0] inc, logic [2:0] ty, logic [7:0] duty, logic [7:0] amp);
        cfg_phase_inc = inc; cfg_sig_type = ty; cfg_duty = duty; cfg_amp = amp;
        cfg_valid = 1'b1;
        for (int i = 0; i < 1200; i++) begin
            tick();
            if (accepted) break;
        end
        cfg_valid = 1'b0;
        check("accept_timeout", accepted, 1);
    endtask

    task automatic wait_ready();
        for (int i = 0; i < 1200 && !ready1; i++) tick();
        check("ready_timeout", ready1, 1);
    endtask

    initial begin
        int unsigned highs, maxv;
        bit found;
        for (int i = 0; i < 1024; i++) lut[i] = 8'($urandom_range(0, 255));
        model_reset();

        // Reset held two cycles, then released.
        rst = 1'b1;
        run(2);
        rst = 1'b0;
        tick();
        check("ready_after_rst", ready1, 1);

        // Square, 16-cycle period, applied while idle.
        en = 1'b0;
        offer(32'h1000_0000, SQUARE, 8'd0, 8'hff);
        wait_ready();
        en = 1'b1;
        run(40);

        // PWM with duty 64 over a 256-sample period, applied at the square wrap.
        offer(32'h0100_0000, PWM, 8'd64, 8'hff);
        wait_ready();
        found = 0;
        for (int i = 0; i < 600 && !found; i++) begin
            tick();
            if (v1 && cs1) found = 1;
        end
        check("pwm_start_found", found, 1);
        highs = (smp1 != 0) ? 1 : 0;
        for (int i = 1; i < 256; i++) begin
            tick();
            if (smp1 != 0) highs++;
        end
        check("pwm_highs", highs, 64);

        // Sine through both BRAM latencies, covering the address wrap 1023 -> 0.
        offer(32'h0040_0000, SINE, 8'd0, 8'hff);
        wait_ready();
        run(1100);

        // Triangle, then sawtooth offered mid-period.
        offer(32'h1000_0000, TRIANGLE, 8'd0, 8'hff);
        wait_ready();
        run(7);
        offer(32'h1000_0000, SAWTOOTH, 8'd0, 8'hff);
        found = 0;
        for (int i = 0; i < 40 && !found; i++) begin
            tick();
            if (v1 && cs1) found = 1;
        end
        check("saw_start_found", found, 1);
        check("saw_first", smp1, 0);
        run(20);

        // Square at half amplitude.
        offer(32'h1000_0000, SQUARE, 8'd0, 8'd128);
        wait_ready();
        maxv = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (v1 && smp1 > maxv) maxv = smp1;
        end
        check("amp_high", maxv, AMP_EN ? 127 : 255);

        // Random configurations with random enable gaps and undefined type codes.
        for (int k = 0; k < 12; k++) begin
            en = 1'($urandom_range(0, 1));
            offer($urandom | 32'h0400_0000, 3'($urandom_range(0, 7)),
                  8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
            for (int i = 0; i < 40; i++) begin
                en = ($urandom_range(0, 3) != 0);
                tick();
            end
        end

        // Reset with a config pending in the shadow: it must be discarded.
        en = 1'b1;
        offer(32'h0010_0000, SAWTOOTH, 8'd0, 8'hff);
        wait_ready();
        run(5);
        offer(32'h1000_0000, SQUARE, 8'd0, 8'hff);
        rst = 1'b1;
        tick();
        check("ready_in_rst", ready1, 0);
        rst = 1'b0;
        run(12);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
